ro_slot_scheduler: RTL
======================

Name: ro_slot_scheduler

Overview:
Time-division readout scheduler for the core array.
- Runs a binary counter and drives the gray-coded clock bus to the per-core readout blocks.
- On every master-clock edge, exactly one gray bit toggles. The scheduler grants the output slot to the core owning that bit and serialises that core's event and polarity bits onto one shared output with a channel tag.
- Faster cores, which own low gray bits, get proportionally more slots. This replaces free-running gray counting with start/stop/drain control and per-core masking.

Parameters:
- N_CH, 8: number of cores and width of the gray bus (N_CH >= 2).
- CH_W, $clog2(N_CH): width of the channel tag; derived, never overridden.

Ports:
- clk_master  in  1  master clock; all state updates on its rising edge.
- rstb  in  1  asynchronous, active-low reset.
- run  in  1  level request to scan; sampled every edge.
- ch_mask  in  N_CH  1 = core k excluded from output; sampled on its slot edge.
- in_eve  in  N_CH  event bit per core.
- in_pol_eve  in  N_CH  polarity-event bit per core.
- gray_out  out  N_CH  registered gray code of the counter, fed to the readout blocks.
- grant  out  N_CH  registered one-hot slot grant, gated by mask; all-zero when no grant.
- out_eve  out  1  serialised event bit.
- out_pol_eve  out  1  serialised polarity bit.
- out_ch  out  CH_W  channel index of the current output data.
- out_valid  out  1  output data is valid.
- frame_start  out  1  one-cycle pulse with the grant issued as the counter leaves 0.
- busy  out  1  state != IDLE, or out_valid is high.

Behaviour:
- Reset (rstb=0, async): state=IDLE; cnt, gray_out, grant, out_eve, out_pol_eve, out_ch, out_valid, frame_start, busy all 0.
- State: cnt is N_CH bits; gray_out = cnt ^ (cnt>>1), registered with cnt.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: cnt held at 0, grant=0. If run=1, go to RUN on this edge; the first increment happens on the next edge.
  - RUN: cnt <= cnt+1 mod 2^N_CH every edge. If run=0, go to DRAIN on the same edge; the increment still occurs.
  - DRAIN: keep incrementing. If run=1, return to RUN with no gap. On the edge where cnt goes 2^N_CH-1 -> 0, go to IDLE.
- Slot index on each increment edge, with n = cnt+1 mod 2^N_CH:
  - k = trailing-zero count of n if n != 0; k = N_CH-1 if n == 0.
  - This equals the one gray bit that toggles.
  - grant <= (1<<k) & ~ch_mask, registered on the same edge as gray_out.
- Slot rates:
  - Core k < N_CH-1 is granted every 2^(k+1) cycles.
  - Core N_CH-1 is granted every 2^(N_CH-1) cycles, the same rate as core N_CH-2.
  - Per frame of 2^N_CH cycles: core k gets 2^(N_CH-1-k) slots, except core N_CH-1 gets 2. The sum is 2^N_CH.
- Data latency is 1 cycle after grant. On the edge after a grant to k:
  - out_ch <= k.
  - out_eve <= in_eve[k] and out_pol_eve <= in_pol_eve[k], sampled at that edge.
  - out_valid <= 1.
- Masked slot: grant=0, and on the following edge out_valid=0, out_eve=0, out_pol_eve=0, out_ch=k. gray_out still toggles, because the mask never affects counting.
- frame_start=1 in the cycle whose grant was issued by the 0 -> 1 increment (k=0), mask-independent.
- Wrap edge (n=0) in DRAIN: still issues the core N_CH-1 grant. On the next edge: grant <= 0, and that slot's data is emitted with out_valid as normal; out_valid clears one edge later. busy falls with out_valid.
- IDLE and no pending data: grant=0 and out_valid=0. gray_out is 0 because cnt is 0.
- Reset mid-frame aborts immediately. There is no drain and no partial output after rstb rises; restart begins from cnt=0.

Optional Feature:
- RO_PARITY_EN: adds output out_par (1 bit), registered alongside the data.
  - out_par = out_eve ^ out_pol_eve ^ (XOR of out_ch bits).
  - out_par = 0 when out_valid=0; reset value 0.
- Without the macro, the out_par port and its logic are absent; all other behaviour is identical.

Test Plan:
- Run scan (N_CH=4, mask=0, run=1 from reset release): over 16 edges after the first increment, grant sequence is ch0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,3. Counts are 8/4/2/2. gray_out changes by exactly one bit per edge.
- Data path (in_eve=4'b0101, in_pol_eve=4'b0011): on the cycle after each grant to k, out_ch=k and out_eve/out_pol_eve match in_eve[k]/in_pol_eve[k], with out_valid=1. frame_start pulses once per 16 cycles.
- Mask (ch_mask=4'b0010): grant[1] is never asserted. The 4 ch1 slots per frame give out_valid=0, out_eve=0 and out_ch=1, while gray_out bit1 still toggles.
- Drain (drop run at cnt=5): counting continues to wrap, with the last grant=ch3 at the 15 -> 0 edge. Next cycle out_ch=3 and out_valid=1; then IDLE, busy=0, gray_out=0. Re-raising run at cnt=9 instead continues with no gap.
- Async reset (assert rstb=0 mid-frame between edges): all outputs go to 0 immediately. After release with run=1, the first grant is ch0 with frame_start.
- With RO_PARITY_EN (out_eve=1, out_pol_eve=0, out_ch=3): out_par=1. With out_valid=0: out_par=0.

Source files
------------

// File: rtl/ro_slot_scheduler.sv
// Gray-coded time-division readout scheduler; the optional out_par port is enabled by RO_PARITY_EN.
// Grant is registered with gray_out and data follows one cycle later; there is no backpressure (one slot per edge).
// run/stop/drain control stops the counter only after it wraps to 0, so every frame completes.
module ro_slot_scheduler #(
    parameter  int N_CH = 8,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic            clk_master,
    input  logic            rstb,
    input  logic            run,
    input  logic [N_CH-1:0] ch_mask,
    input  logic [N_CH-1:0] in_eve,
    input  logic [N_CH-1:0] in_pol_eve,
    output logic [N_CH-1:0] gray_out,
    output logic [N_CH-1:0] grant,
    output logic            out_eve,
    output logic            out_pol_eve,
    output logic [CH_W-1:0] out_ch,
    output logic            out_valid,
    output logic            frame_start,
`ifdef RO_PARITY_EN
    output logic            out_par,
`endif
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    logic [N_CH-1:0] cnt;
    logic [N_CH-1:0] cnt_nxt;
    logic [CH_W-1:0] k_nxt;
    logic [CH_W-1:0] slot_k;
    logic            slot_act;

    // Slot owner is the trailing-zero count of the next count; the wrap to 0 belongs to the top core.
    function automatic logic [CH_W-1:0] slot_of(input logic [N_CH-1:0] n);
        slot_of = CH_W'(N_CH - 1);
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (n[i]) slot_of = CH_W'(i);
        end
    endfunction

    always_comb begin
        cnt_nxt = cnt + {{(N_CH-1){1'b0}}, 1'b1};
        k_nxt   = slot_of(cnt_nxt);
    end

    assign busy = (state != IDLE) || out_valid;

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            cnt         <= '0;
            gray_out    <= '0;
            grant       <= '0;
            slot_k      <= '0;
            slot_act    <= 1'b0;
            out_eve     <= 1'b0;
            out_pol_eve <= 1'b0;
            out_ch      <= '0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
`ifdef RO_PARITY_EN
            out_par     <= 1'b0;
`endif
        end else begin
            // Data stage: a masked slot still reports its channel but carries no data.
            if (slot_act) begin
                out_ch      <= slot_k;
                out_valid   <= |grant;
                out_eve     <= (|grant) & in_eve[slot_k];
                out_pol_eve <= (|grant) & in_pol_eve[slot_k];
`ifdef RO_PARITY_EN
                out_par     <= (|grant) & (in_eve[slot_k] ^ in_pol_eve[slot_k] ^ (^slot_k));
`endif
            end else begin
                out_valid   <= 1'b0;
                out_eve     <= 1'b0;
                out_pol_eve <= 1'b0;
`ifdef RO_PARITY_EN
                out_par     <= 1'b0;
`endif
            end

            grant       <= '0;
            slot_act    <= 1'b0;
            frame_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (run) state <= RUN;
                end
                RUN, DRAIN: begin
                    cnt         <= cnt_nxt;
                    gray_out    <= cnt_nxt ^ (cnt_nxt >> 1);
                    grant       <= ({{(N_CH-1){1'b0}}, 1'b1} << k_nxt) & ~ch_mask;
                    slot_k      <= k_nxt;
                    slot_act    <= 1'b1;
                    frame_start <= (cnt == '0);
                    if (run)                 state <= RUN;
                    else if (state == RUN)   state <= DRAIN;
                    else if (cnt_nxt == '0)  state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
